// File: rtl/opcode_fetch_unit.sv
// Instruction assembler between the data bus buffer and the decoder: collects the
// opcode plus 0-2 operand bytes and hands the instruction over through valid/ready.
module opcode_fetch_unit #(
  parameter logic [7:0] INT_OPCODE = 8'h00,
  parameter logic [1:0] FORCE_LEN  = 2'd1
) (
  input  logic       fclk,
  input  logic       resb,
  input  logic       rdy,
  input  logic [7:0] db_in,
  input  logic       data_strobe,
  input  logic       flush,
  input  logic       int_req,
  input  logic       out_ready,
  output logic       sync,
  output logic       buf_load,
  output logic       pc_inc,
  output logic       out_valid,
  output logic [7:0] out_opcode,
  output logic [7:0] out_op_lo,
  output logic [7:0] out_op_hi,
  output logic [1:0] out_len,
  output logic       out_int
);

  typedef enum logic [1:0] {S_OPCODE, S_OPER1, S_OPER2, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  op_lo_q, op_lo_d;
  logic [7:0]  op_hi_q, op_hi_d;
  logic [1:0]  len_q, len_d;
  logic        valid_q, valid_d;
  logic        int_q, int_d;
  logic        fetch_st;
  logic        take_int;
  logic        take_byte;

  // 65C02 instruction length from the opcode byte
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] len;
    case (op[3:0])
      4'h0: begin
        if (op == 8'h20)                      len = 2'd3;
        else if (op == 8'h40 || op == 8'h60)  len = 2'd1;
        else                                  len = 2'd2;
      end
      4'h3, 4'h8, 4'hA, 4'hB:                 len = 2'd1;
      4'h9:                                   len = op[4] ? 2'd3 : 2'd2;
      4'hC, 4'hD, 4'hE, 4'hF:                 len = 2'd3;
      default:                                len = 2'd2;
    endcase
    return len;
  endfunction

  assign fetch_st  = (state_q != S_HOLD);
  assign take_int  = (state_q == S_OPCODE) && rdy && int_req && !flush;
  assign take_byte = fetch_st && rdy && data_strobe && !flush && !take_int;

  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      state_q  <= S_OPCODE;
      opcode_q <= 8'h00;
      op_lo_q  <= 8'h00;
      op_hi_q  <= 8'h00;
      len_q    <= 2'd1;
      valid_q  <= 1'b0;
      int_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      op_lo_q  <= op_lo_d;
      op_hi_q  <= op_hi_d;
      len_q    <= len_d;
      valid_q  <= valid_d;
      int_q    <= int_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    op_lo_d  = op_lo_q;
    op_hi_d  = op_hi_q;
    len_d    = len_q;
    valid_d  = valid_q;
    int_d    = int_q;
    if (flush) begin
      state_d = S_OPCODE;
      valid_d = 1'b0;
      int_d   = 1'b0;
      op_lo_d = 8'h00;
      op_hi_d = 8'h00;
    end else begin
      case (state_q)
        S_OPCODE: begin
          if (take_int) begin
            opcode_d = INT_OPCODE;
            len_d    = FORCE_LEN;
            int_d    = 1'b1;
            op_lo_d  = 8'h00;
            op_hi_d  = 8'h00;
            valid_d  = 1'b1;
            state_d  = S_HOLD;
          end else if (take_byte) begin
            opcode_d = db_in;
            len_d    = op_len(db_in);
            op_lo_d  = 8'h00;
            op_hi_d  = 8'h00;
            if (op_len(db_in) > 2'd1) begin
              state_d = S_OPER1;
            end else begin
              valid_d = 1'b1;
              state_d = S_HOLD;
            end
          end
        end
        S_OPER1: begin
          if (take_byte) begin
            op_lo_d = db_in;
            if (len_q == 2'd3) begin
              state_d = S_OPER2;
            end else begin
              valid_d = 1'b1;
              state_d = S_HOLD;
            end
          end
        end
        S_OPER2: begin
          if (take_byte) begin
            op_hi_d = db_in;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end
        default: begin
          // decoder handshake is independent of RDY
          if (out_ready) begin
            valid_d = 1'b0;
            int_d   = 1'b0;
            state_d = S_OPCODE;
          end
        end
      endcase
    end
  end

  always_comb begin
    sync       = (state_q == S_OPCODE);
    buf_load   = fetch_st && rdy;
    pc_inc     = take_byte && resb;
    out_valid  = valid_q;
    out_opcode = opcode_q;
    out_op_lo  = op_lo_q;
    out_op_hi  = op_hi_q;
    out_len    = len_q;
    out_int    = int_q;
  end

endmodule

// File: tb/tb_opcode_fetch_unit.sv
// Directed bench for opcode_fetch_unit: handshake, hold, RDY stall, interrupt
// injection, flush, asynchronous reset and a full length-table sweep.
module tb_opcode_fetch_unit;

  logic       fclk = 1'b0;
  logic       resb;
  logic       rdy;
  logic [7:0] db_in;
  logic       data_strobe;
  logic       flush;
  logic       int_req;
  logic       out_ready;
  logic       sync;
  logic       buf_load;
  logic       pc_inc;
  logic       out_valid;
  logic [7:0] out_opcode;
  logic [7:0] out_op_lo;
  logic [7:0] out_op_hi;
  logic [1:0] out_len;
  logic       out_int;

  int total = 0;
  int bad   = 0;
  int pc_cnt = 0;

  opcode_fetch_unit #(.INT_OPCODE(8'h00), .FORCE_LEN(2'd1)) dut (
    .fclk(fclk), .resb(resb), .rdy(rdy), .db_in(db_in), .data_strobe(data_strobe),
    .flush(flush), .int_req(int_req), .out_ready(out_ready), .sync(sync),
    .buf_load(buf_load), .pc_inc(pc_inc), .out_valid(out_valid),
    .out_opcode(out_opcode), .out_op_lo(out_op_lo), .out_op_hi(out_op_hi),
    .out_len(out_len), .out_int(out_int)
  );

  always #5 fclk = ~fclk;

  always @(posedge fclk) if (pc_inc) pc_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference length table written as explicit opcode-class rules
  function automatic logic [1:0] ref_len(input logic [7:0] op);
    logic [3:0] l;
    l = op[3:0];
    if (op == 8'h20) return 2'd3;
    if (op == 8'h40 || op == 8'h60) return 2'd1;
    if (l >= 4'hC) return 2'd3;
    if (l == 4'h3 || l == 4'hB || l == 4'h8 || l == 4'hA) return 2'd1;
    if (l == 4'h9) return (op[7:4] % 2 == 1) ? 2'd3 : 2'd2;
    return 2'd2;
  endfunction

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    db_in = b;
    data_strobe = 1'b1;
    tick();
    data_strobe = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    resb = 1'b0; rdy = 1'b1; db_in = 8'h00; data_strobe = 1'b0;
    flush = 1'b0; int_req = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_len", out_len, 1);
    chk("rst_opcode", out_opcode, 8'h00);
    chk("rst_int", out_int, 0);
    chk("rst_pcinc", pc_inc, 0);
    resb = 1'b1;
    tick();
    chk("rst_sync", sync, 1);
    chk("rst_bufload", buf_load, 1);

    // two-byte instruction with decoder always ready
    out_ready = 1'b1;
    pc_cnt = 0;
    strobe(8'hA9);
    chk("a9_sync_oper1", sync, 0);
    strobe(8'h42);
    chk("a9_valid", out_valid, 1);
    chk("a9_opcode", out_opcode, 8'hA9);
    chk("a9_lo", out_op_lo, 8'h42);
    chk("a9_hi", out_op_hi, 8'h00);
    chk("a9_len", out_len, 2);
    tick();
    chk("a9_valid_drop", out_valid, 0);
    chk("a9_sync", sync, 1);
    chk("a9_pcinc", pc_cnt, 2);
    out_ready = 1'b0;

    // three-byte instruction held while decoder stalls, HOLD strobes ignored
    pc_cnt = 0;
    strobe(8'h20); strobe(8'h34); strobe(8'h12);
    for (int i = 0; i < 5; i++) begin
      db_in = 8'hFF;
      data_strobe = 1'b1;
      tick();
      chk("jsr_valid_hold", out_valid, 1);
      chk("jsr_lo_hold", out_op_lo, 8'h34);
      chk("jsr_hi_hold", out_op_hi, 8'h12);
      chk("jsr_len_hold", out_len, 3);
      chk("jsr_opc_hold", out_opcode, 8'h20);
    end
    data_strobe = 1'b0;
    chk("jsr_bufload_hold", buf_load, 0);
    chk("jsr_pcinc", pc_cnt, 3);
    handshake();
    chk("jsr_release", out_valid, 0);

    // RDY stall between opcode and operands
    pc_cnt = 0;
    strobe(8'hAD);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) strobe(8'h55);
    chk("rdy_bufload", buf_load, 0);
    chk("rdy_pcinc", pc_cnt, 1);
    chk("rdy_lo", out_op_lo, 8'h00);
    rdy = 1'b1;
    strobe(8'h00); strobe(8'h80);
    chk("ad_valid", out_valid, 1);
    chk("ad_opcode", out_opcode, 8'hAD);
    chk("ad_lo", out_op_lo, 8'h00);
    chk("ad_hi", out_op_hi, 8'h80);
    chk("ad_len", out_len, 3);
    chk("ad_pcinc", pc_cnt, 3);
    handshake();

    // interrupt injected at the boundary
    pc_cnt = 0;
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    chk("int_valid", out_valid, 1);
    chk("int_opcode", out_opcode, 8'h00);
    chk("int_flag", out_int, 1);
    chk("int_len", out_len, 1);
    chk("int_pcinc", pc_cnt, 0);
    handshake();
    chk("int_flag_clr", out_int, 0);

    // flush while the operand byte of 8D arrives
    pc_cnt = 0;
    strobe(8'h8D);
    flush = 1'b1; db_in = 8'h10; data_strobe = 1'b1;
    #1;
    chk("flush_pcinc_now", pc_inc, 0);
    tick();
    flush = 1'b0; data_strobe = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_sync", sync, 1);
    chk("flush_lo", out_op_lo, 8'h00);
    chk("flush_pcinc", pc_cnt, 1);
    strobe(8'hEA);
    chk("ea_valid", out_valid, 1);
    chk("ea_opcode", out_opcode, 8'hEA);
    chk("ea_len", out_len, 1);

    // asynchronous reset while holding
    #2 resb = 1'b0;
    #1;
    chk("areset_valid", out_valid, 0);
    chk("areset_opcode", out_opcode, 8'h00);
    #2 resb = 1'b1;
    tick();
    chk("areset_sync", sync, 1);

    // full opcode sweep against the reference length table
    for (int op = 0; op < 256; op++) begin
      logic [1:0] m;
      m = ref_len(op[7:0]);
      strobe(op[7:0]);
      for (int k = 1; k < int'(m); k++) strobe(8'h5A);
      chk($sformatf("len_%02h", op), out_len, m);
      chk($sformatf("vld_%02h", op), out_valid, 1);
      handshake();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/opcode_fetch_unit.md
Name: opcode_fetch_unit

Overview:
- Sits directly downstream of the data bus buffer; consumes its registered read-data output (db_out).
- Assembles each instruction: one opcode byte plus 0–2 operand bytes, with the count set by a fixed 65C02 length table.
- Presents the assembled instruction to the instruction decoder through a valid/ready handshake.
- Drives SYNC, the buffer load enable (the buffer's instruction_decode_in) and the PC-increment request.

Parameters:
- INT_OPCODE, 8'h00, opcode injected when an interrupt is taken at an instruction boundary.
- FORCE_LEN, 2'd1, length reported for an injected interrupt instruction.

Ports:
- fclk  in  1  system clock; all state updates on the rising edge.
- resb  in  1  asynchronous active-low reset.
- rdy  in  1  65C02 RDY; low freezes the FSM and blocks sampling.
- db_in  in  8  read data from the data bus buffer db_out.
- data_strobe  in  1  one-cycle pulse: db_in holds a completed read byte this cycle.
- flush  in  1  discard in-flight/held instruction, restart at opcode fetch (branch taken, reset vector).
- int_req  in  1  pending IRQ/NMI, sampled only at the instruction boundary.
- out_ready  in  1  decoder accepts the instruction.
- sync  out  1  high while in OPCODE state.
- buf_load  out  1  drives the buffer's instruction_decode_in; equals fetch state && rdy.
- pc_inc  out  1  one-cycle pulse per accepted fetched byte.
- out_valid  out  1  instruction held and valid.
- out_opcode  out  8  opcode.
- out_op_lo  out  8  first operand byte (8'h00 if absent).
- out_op_hi  out  8  second operand byte (8'h00 if absent).
- out_len  out  2  instruction length, 1..3.
- out_int  out  1  instruction is an injected interrupt.

Behaviour:
- Reset (resb low, asynchronous):
  - state = OPCODE.
  - All output registers cleared: out_valid=0, out_int=0, out_len=2'd1, opcode/operands=8'h00.
  - pc_inc=0; sync=1 once resb is high.
- FSM states: OPCODE, OPER1, OPER2, HOLD.
  - OPCODE, int_req=1 at entry cycle, no strobe: load INT_OPCODE, len=FORCE_LEN, out_int=1, no pc_inc; go to HOLD.
  - OPCODE, strobe with rdy (int_req=0): capture opcode, compute len, pc_inc=1. Next state is OPER1 if len>1, else HOLD.
  - OPER1, strobe with rdy: capture op_lo, pc_inc=1. Next state is OPER2 if len=3, else HOLD.
  - OPER2, strobe with rdy: capture op_hi, pc_inc=1; go to HOLD.
  - HOLD: out_valid=1. On out_ready=1, clear out_valid and out_int and go to OPCODE. The next opcode fetch needs a fresh strobe, so minimum issue spacing is len+1 cycles.
- rdy=0: no sampling, no pc_inc, no transition; HOLD handshake is still honoured (RDY does not gate the decoder interface).
- data_strobe outside a fetch state (HOLD): ignored.
- Priority per cycle: resb > flush > handshake/strobe.
  - flush: state becomes OPCODE, out_valid=0, out_int=0, operand registers zeroed, pc_inc=0 that cycle.
  - A concurrent out_ready handshake is void.
- Operand registers are zeroed at each opcode capture, so absent operands read 8'h00.
- int_req arriving mid-instruction is ignored until the FSM returns to OPCODE.
- Length table, indexed by low nibble L and high nibble H:
  - L=0: 20→3; 40,60→1; all others→2.
  - L=1,2,4,5,6,7→2.
  - L=3,B→1.
  - L=8,A→1.
  - L=9: H odd→3, H even→2.
  - L=C,D,E,F→3.
- Latency: out_valid rises the cycle after the final byte's strobe.

Test Plan:
- Strobes A9,42 with out_ready=1 → pc_inc twice; out_valid one cycle with opcode A9, op_lo 42, op_hi 00, len 2; then sync=1.
- Strobes 20,34,12 with out_ready=0 for 5 cycles → valid held stable with len 3, 34/12; no extra pc_inc. Strobes during HOLD are ignored.
- rdy=0 for 3 cycles between opcode AD and operand strobes → no capture, no pc_inc; the final instruction is AD,00,80, len 3.
- int_req=1 at boundary → opcode 00, out_int=1, len 1, zero pc_inc.
- Flush during OPER1 of 8D (operand 10 pending) → state OPCODE, out_valid stays 0; next strobe EA yields len-1 instruction EA.
- resb pulsed low while in HOLD → out_valid=0 immediately (asynchronous), sync=1 after release.
- Sweep all 256 opcodes → out_len matches the table, e.g. 89→2, 99→3, CB→1, 0F→3.
